branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the one-hot branch-type flags from the branch decoder (beq, bne, blt, bge, bltu, bgeu).
- Compares rs1/rs2 and computes the target PC+imm.
- When a branch is taken, issues a held PC redirect to fetch, then squashes KILL_SLOTS wrong-path instructions.
- Keeps wrap-around branch and taken counters for performance measurement.

---
 rtl/branch_resolve_unit_pkg.sv | 43 ++++
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/branch_resolve_unit_compare.sv | 37 +++
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 tb/tb_branch_resolve_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the execute-stage branch resolver: FSM states, branch kinds
// and the flag-to-kind priority encoder.
package branch_resolve_unit_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } br_state_t;

    // Kinds reuse the funct3 encoding; 3'b010 is not a branch funct3, so it marks "none".
    typedef enum logic [2:0] {
        BR_EQ   = F3_BEQ,
        BR_NE   = F3_BNE,
        BR_NONE = 3'b010,
        BR_LT   = F3_BLT,
        BR_GE   = F3_BGE,
        BR_LTU  = F3_BLTU,
        BR_GEU  = F3_BGEU
    } br_kind_t;

    // flags = {beq, bne, blt, bge, bltu, bgeu}; leftmost set flag wins.
    function automatic br_kind_t flags_to_kind(input logic [5:0] flags);
        br_kind_t k;
        if (flags[5])      k = BR_EQ;
        else if (flags[4]) k = BR_NE;
        else if (flags[3]) k = BR_LT;
        else if (flags[2]) k = BR_GE;
        else if (flags[1]) k = BR_LTU;
        else if (flags[0]) k = BR_GEU;
        else               k = BR_NONE;
        return k;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Upstream instruction handshake, fetch redirect handshake and status outputs
// of the branch resolver, bundled as one interface.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // Both handshakes transfer on a cycle where valid && ready; the valid side
    // holds its payload stable until that cycle.
    logic             in_valid;
    logic             in_ready;
    logic             beq;
    logic             bne;
    logic             blt;
    logic             bge;
    logic             bltu;
    logic             bgeu;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             redir_valid;
    logic             redir_ready;
    logic [XLEN-1:0]  redir_pc;
    logic             kill;
    logic             misalign;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output in_valid, beq, bne, blt, bge, bltu, bgeu,
               rs1_val, rs2_val, pc, imm, redir_ready,
        input  in_ready, redir_valid, redir_pc, kill, misalign,
               branch_cnt, taken_cnt
    );

    modport slave (
        input  in_valid, beq, bne, blt, bge, bltu, bgeu,
               rs1_val, rs2_val, pc, imm, redir_ready,
        output in_ready, redir_valid, redir_pc, kill, misalign,
               branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition: one-hot (priority-resolved) flags plus the
// two operands produce a branch/taken decision.
module branch_resolve_unit_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      flags_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            is_branch_o,
    output logic            taken_o
);
    br_kind_t kind;
    logic     eq;
    logic     lt;
    logic     ltu;

    assign kind        = flags_to_kind(flags_i);
    assign eq          = (rs1_i == rs2_i);
    assign lt          = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu         = (rs1_i < rs2_i);
    assign is_branch_o = (kind != BR_NONE);

    always_comb begin
        taken_o = 1'b0;
        case (kind)
            BR_EQ:   taken_o = eq;
            BR_NE:   taken_o = !eq;
            BR_LT:   taken_o = lt;
            BR_GE:   taken_o = !lt;
            BR_LTU:  taken_o = ltu;
            BR_GEU:  taken_o = !ltu;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: decides taken branches, holds a redirect to
// fetch until accepted, then squashes KILL_SLOTS wrong-path slots.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int KILL_SLOTS = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus,
    output br_state_t             state_dbg_o
);
    br_state_t        state_q, state_d;
    logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
    logic [2:0]       squash_q, squash_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [5:0]       flags;
    logic             is_branch;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             aligned;
    logic             idle_accept;
    logic             in_ready;

    assign flags = {bus.beq, bus.bne, bus.blt, bus.bge, bus.bltu, bus.bgeu};

    branch_resolve_unit_compare #(.XLEN(XLEN)) u_compare (
        .flags_i     (flags),
        .rs1_i       (bus.rs1_val),
        .rs2_i       (bus.rs2_val),
        .is_branch_o (is_branch),
        .taken_o     (taken)
    );

    assign target      = bus.pc + bus.imm;
    assign aligned     = (target[1:0] == 2'b00);
    // Squash-cycle accepts fall outside IDLE, so they are dropped without counting.
    assign idle_accept = bus.in_valid && in_ready && (state_q == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            redir_pc_q   <= '0;
            squash_q     <= '0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            redir_pc_q   <= redir_pc_d;
            squash_q     <= squash_d;
            misalign_q   <= misalign_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        redir_pc_d   = redir_pc_q;
        squash_d     = squash_q;
        misalign_d   = 1'b0;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        case (state_q)
            IDLE: begin
                if (idle_accept && is_branch) begin
                    branch_cnt_d = branch_cnt_q + 1'b1;
                    if (taken && aligned) begin
                        taken_cnt_d = taken_cnt_q + 1'b1;
                        redir_pc_d  = target;
                        state_d     = REDIRECT;
                    end else if (taken) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                if (bus.redir_ready) begin
                    if (KILL_SLOTS == 0) begin
                        state_d = IDLE;
                    end else begin
                        squash_d = 3'(KILL_SLOTS);
                        state_d  = SQUASH;
                    end
                end
            end
            SQUASH: begin
                squash_d = squash_q - 3'd1;
                if (squash_q <= 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready        = (state_q != REDIRECT);
        bus.in_ready    = in_ready;
        bus.redir_valid = (state_q == REDIRECT);
        bus.kill        = (state_q == SQUASH);
        bus.redir_pc    = redir_pc_q;
        bus.misalign    = misalign_q;
        bus.branch_cnt  = branch_cnt_q;
        bus.taken_cnt   = taken_cnt_q;
        state_dbg_o     = state_q;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: default build plus KILL_SLOTS=0 and CNT_W=4 builds.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam logic [5:0] F_BEQ  = 6'b100000;
  localparam logic [5:0] F_BNE  = 6'b010000;
  localparam logic [5:0] F_BLT  = 6'b001000;
  localparam logic [5:0] F_BGE  = 6'b000100;
  localparam logic [5:0] F_BLTU = 6'b000010;
  localparam logic [5:0] F_BGEU = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_branch;
  logic [31:0] exp_taken;
  br_state_t st, st_k0, st_c4;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus_k0 ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(4))  bus_c4 ();

  branch_resolve_unit #(.XLEN(32), .KILL_SLOTS(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg_o(st));
  branch_resolve_unit #(.XLEN(32), .KILL_SLOTS(0), .CNT_W(32)) dut_k0 (
    .clk(clk), .reset(reset), .bus(bus_k0), .state_dbg_o(st_k0));
  branch_resolve_unit #(.XLEN(32), .KILL_SLOTS(2), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .bus(bus_c4), .state_dbg_o(st_c4));

  // ---------------- scoreboard: redirect handshakes ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.redir_valid === 1'b1 && bus.redir_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL redir_unexpected got=%h exp=none", bus.redir_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.redir_pc !== e) begin
          bad++;
          $display("FAIL redir_pc got=%h exp=%h", bus.redir_pc, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and drivers ----------------
  function automatic logic model_taken(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[5]) return a == b;
    if (f[4]) return a != b;
    if (f[3]) return $signed(a) < $signed(b);
    if (f[2]) return $signed(a) >= $signed(b);
    if (f[1]) return a < b;
    if (f[0]) return a >= b;
    return 1'b0;
  endfunction

  task automatic set_flags(input logic [5:0] f);
    {bus.beq, bus.bne, bus.blt, bus.bge, bus.bltu, bus.bgeu} = f;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_br(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] i);
    logic [31:0] tgt;
    int n;
    tgt = p + i;
    n = 0;
    while (!(bus.in_ready === 1'b1 && bus.kill === 1'b0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL drive_wait got=busy exp=idle");
    end
    set_flags(f);
    bus.rs1_val = a; bus.rs2_val = b; bus.pc = p; bus.imm = i;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    set_flags(6'b0);
    if (f != 6'b0) begin
      exp_branch++;
      if (model_taken(f, a, b) && tgt[1:0] == 2'b00) begin
        exp_taken++;
        exp_q.push_back(tgt);
      end
    end
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    for (n = 0; n < 60; n++) begin
      if (bus.in_ready === 1'b1 && bus.kill === 1'b0) break;
      if (rnd) bus.redir_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if (n == 60) begin
      total++; bad++;
      $display("FAIL wait_idle got=busy exp=idle");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 0; set_flags(0); bus.rs1_val = 0; bus.rs2_val = 0; bus.pc = 0; bus.imm = 0; bus.redir_ready = 0;
    bus_k0.in_valid = 0; {bus_k0.beq, bus_k0.bne, bus_k0.blt, bus_k0.bge, bus_k0.bltu, bus_k0.bgeu} = 0;
    bus_k0.rs1_val = 0; bus_k0.rs2_val = 0; bus_k0.pc = 0; bus_k0.imm = 0; bus_k0.redir_ready = 1;
    bus_c4.in_valid = 0; {bus_c4.beq, bus_c4.bne, bus_c4.blt, bus_c4.bge, bus_c4.bltu, bus_c4.bgeu} = 0;
    bus_c4.rs1_val = 0; bus_c4.rs2_val = 0; bus_c4.pc = 0; bus_c4.imm = 0; bus_c4.redir_ready = 1;
    exp_branch = 0; exp_taken = 0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL reset_redir_valid got=%b exp=0", bus.redir_valid); end
    total++; if (bus.redir_pc !== 32'h0) begin bad++; $display("FAIL reset_redir_pc got=%h exp=0", bus.redir_pc); end
    total++; if (bus.kill !== 1'b0) begin bad++; $display("FAIL reset_kill got=%b exp=0", bus.kill); end
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
    total++; if (bus.branch_cnt !== 32'h0) begin bad++; $display("FAIL reset_branch_cnt got=%0d exp=0", bus.branch_cnt); end
    total++; if (bus.taken_cnt !== 32'h0) begin bad++; $display("FAIL reset_taken_cnt got=%0d exp=0", bus.taken_cnt); end
    total++; if (st !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st, IDLE); end
  endtask

  task automatic test_beq_taken;
    int kc;
    bus.redir_ready = 1'b1;
    drive_br(F_BEQ, 32'd5, 32'd5, 32'h100, 32'h20);
    total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL beq_redir_valid got=%b exp=1", bus.redir_valid); end
    total++; if (bus.redir_pc !== 32'h120) begin bad++; $display("FAIL beq_redir_pc got=%h exp=120", bus.redir_pc); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL beq_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.taken_cnt !== 32'd1) begin bad++; $display("FAIL beq_taken_cnt got=%0d exp=1", bus.taken_cnt); end
    total++; if (bus.branch_cnt !== 32'd1) begin bad++; $display("FAIL beq_branch_cnt got=%0d exp=1", bus.branch_cnt); end
    // A taken wrong-path branch held upstream during the squash must be dropped.
    set_flags(F_BEQ);
    bus.rs1_val = 7; bus.rs2_val = 7; bus.pc = 32'h300; bus.imm = 32'h10;
    bus.in_valid = 1'b1;
    kc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.kill === 1'b1) kc++;
      else if (c > 0) begin bus.in_valid = 1'b0; set_flags(0); end
    end
    bus.in_valid = 1'b0; set_flags(0);
    total++; if (kc !== 2) begin bad++; $display("FAIL beq_kill_cycles got=%0d exp=2", kc); end
    total++; if (bus.branch_cnt !== exp_branch) begin bad++; $display("FAIL squash_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.taken_cnt !== exp_taken) begin bad++; $display("FAIL squash_taken_cnt got=%0d exp=%0d", bus.taken_cnt, exp_taken); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL squash_no_redirect got=%b exp=0", bus.redir_valid); end
  endtask

  task automatic test_signed_unsigned;
    drive_br(F_BLT, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40);
    total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL blt_taken got=%b exp=1", bus.redir_valid); end
    total++; if (bus.redir_pc !== 32'h440) begin bad++; $display("FAIL blt_redir_pc got=%h exp=440", bus.redir_pc); end
    wait_idle(1'b0);
    drive_br(F_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h40);
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL bltu_not_taken got=%b exp=0", bus.redir_valid); end
    total++; if (bus.branch_cnt !== exp_branch) begin bad++; $display("FAIL bltu_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.taken_cnt !== exp_taken) begin bad++; $display("FAIL bltu_taken_cnt got=%0d exp=%0d", bus.taken_cnt, exp_taken); end
  endtask

  task automatic test_stall;
    bus.redir_ready = 1'b0;
    drive_br(F_BNE, 32'd1, 32'd2, 32'h200, 32'h40);
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL stall_redir_valid c=%0d got=%b exp=1", c, bus.redir_valid); end
      total++; if (bus.redir_pc !== 32'h240) begin bad++; $display("FAIL stall_redir_pc c=%0d got=%h exp=240", c, bus.redir_pc); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.redir_ready = 1'b1;
    wait_idle(1'b0);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_misalign;
    drive_br(F_BGE, 32'd7, 32'd3, 32'h100, 32'h2);
    total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL misalign_pulse got=%b exp=1", bus.misalign); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL misalign_redir got=%b exp=0", bus.redir_valid); end
    total++; if (bus.taken_cnt !== exp_taken) begin bad++; $display("FAIL misalign_taken_cnt got=%0d exp=%0d", bus.taken_cnt, exp_taken); end
    total++; if (bus.branch_cnt !== exp_branch) begin bad++; $display("FAIL misalign_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    @(posedge clk); #1;
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL misalign_one_cycle got=%b exp=0", bus.misalign); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL misalign_redir_late got=%b exp=0", bus.redir_valid); end
  endtask

  task automatic test_priority;
    drive_br(F_BEQ | F_BGEU, 32'd9, 32'd3, 32'h600, 32'h8);
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL prio_beq_over_bgeu got=%b exp=0", bus.redir_valid); end
    drive_br(F_BNE | F_BLT, 32'd9, 32'd3, 32'h600, 32'h8);
    total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL prio_bne_over_blt got=%b exp=1", bus.redir_valid); end
    wait_idle(1'b0);
    drive_br(6'b0, 32'd1, 32'd1, 32'h700, 32'h4);
    total++; if (bus.branch_cnt !== exp_branch) begin bad++; $display("FAIL nonbranch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL nonbranch_redir got=%b exp=0", bus.redir_valid); end
  endtask

  task automatic test_back_to_back;
    int kind;
    logic [5:0] f;
    logic [31:0] a, b, p, i;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 6);
      f = (kind == 6) ? 6'b0 : (F_BEQ >> kind);
      a = 32'($urandom_range(0, 3));
      b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = -a;
      p = 32'($urandom_range(0, 255)) * 4;
      i = 32'($urandom_range(0, 8)) * 2;
      drive_br(f, a, b, p, i);
      wait_idle(1'b1);
    end
    bus.redir_ready = 1'b1;
    wait_idle(1'b0);
    total++; if (bus.branch_cnt !== exp_branch) begin bad++; $display("FAIL b2b_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.taken_cnt !== exp_taken) begin bad++; $display("FAIL b2b_taken_cnt got=%0d exp=%0d", bus.taken_cnt, exp_taken); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_squash;
    bus.redir_ready = 1'b1;
    drive_br(F_BEQ, 32'd1, 32'd1, 32'h700, 32'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.kill !== 1'b1) begin bad++; $display("FAIL midsq_kill_before got=%b exp=1", bus.kill); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.kill !== 1'b0) begin bad++; $display("FAIL midsq_kill got=%b exp=0", bus.kill); end
    total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL midsq_redir_valid got=%b exp=0", bus.redir_valid); end
    total++; if (bus.branch_cnt !== 32'h0) begin bad++; $display("FAIL midsq_branch_cnt got=%0d exp=0", bus.branch_cnt); end
    total++; if (bus.taken_cnt !== 32'h0) begin bad++; $display("FAIL midsq_taken_cnt got=%0d exp=0", bus.taken_cnt); end
    total++; if (st !== IDLE) begin bad++; $display("FAIL midsq_state got=%0d exp=%0d", st, IDLE); end
    exp_q.delete();
    exp_branch = 0; exp_taken = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    drive_br(F_BEQ, 32'd4, 32'd4, 32'h800, 32'h100);
    total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL postrst_redir_valid got=%b exp=1", bus.redir_valid); end
    total++; if (bus.redir_pc !== 32'h900) begin bad++; $display("FAIL postrst_redir_pc got=%h exp=900", bus.redir_pc); end
    total++; if (bus.taken_cnt !== 32'd1) begin bad++; $display("FAIL postrst_taken_cnt got=%0d exp=1", bus.taken_cnt); end
    wait_idle(1'b0);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL postrst_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_kill_zero;
    int kc;
    bus_k0.redir_ready = 1'b1;
    {bus_k0.beq, bus_k0.bne, bus_k0.blt, bus_k0.bge, bus_k0.bltu, bus_k0.bgeu} = F_BEQ;
    bus_k0.rs1_val = 0; bus_k0.rs2_val = 0; bus_k0.pc = 32'h40; bus_k0.imm = 32'h40;
    bus_k0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_k0.in_valid = 1'b0;
    {bus_k0.beq, bus_k0.bne, bus_k0.blt, bus_k0.bge, bus_k0.bltu, bus_k0.bgeu} = 6'b0;
    total++; if (bus_k0.redir_valid !== 1'b1) begin bad++; $display("FAIL k0_redir_valid got=%b exp=1", bus_k0.redir_valid); end
    total++; if (bus_k0.redir_pc !== 32'h80) begin bad++; $display("FAIL k0_redir_pc got=%h exp=80", bus_k0.redir_pc); end
    kc = (bus_k0.kill === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    total++; if (st_k0 !== IDLE) begin bad++; $display("FAIL k0_state got=%0d exp=%0d", st_k0, IDLE); end
    total++; if (bus_k0.in_ready !== 1'b1) begin bad++; $display("FAIL k0_in_ready got=%b exp=1", bus_k0.in_ready); end
    total++; if (bus_k0.redir_valid !== 1'b0) begin bad++; $display("FAIL k0_redir_drop got=%b exp=0", bus_k0.redir_valid); end
    for (int c = 0; c < 4; c++) begin
      if (bus_k0.kill === 1'b1) kc++;
      @(posedge clk); #1;
    end
    total++; if (kc !== 0) begin bad++; $display("FAIL k0_kill_cycles got=%0d exp=0", kc); end
    total++; if (bus_k0.taken_cnt !== 32'd1) begin bad++; $display("FAIL k0_taken_cnt got=%0d exp=1", bus_k0.taken_cnt); end
  endtask

  task automatic test_cnt_wrap;
    {bus_c4.beq, bus_c4.bne, bus_c4.blt, bus_c4.bge, bus_c4.bltu, bus_c4.bgeu} = F_BNE;
    bus_c4.rs1_val = 3; bus_c4.rs2_val = 3; bus_c4.pc = 32'h10; bus_c4.imm = 32'h4;
    bus_c4.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 14) begin
        total++; if (bus_c4.branch_cnt !== 4'd15) begin bad++; $display("FAIL wrap_cnt_15 got=%0d exp=15", bus_c4.branch_cnt); end
      end
    end
    bus_c4.in_valid = 1'b0;
    total++; if (bus_c4.branch_cnt !== 4'd0) begin bad++; $display("FAIL wrap_cnt_0 got=%0d exp=0", bus_c4.branch_cnt); end
    total++; if (bus_c4.taken_cnt !== 4'd0) begin bad++; $display("FAIL wrap_taken got=%0d exp=0", bus_c4.taken_cnt); end
    total++; if (st_c4 !== IDLE) begin bad++; $display("FAIL wrap_state got=%0d exp=%0d", st_c4, IDLE); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_signed_unsigned();
    test_stall();
    test_misalign();
    test_priority();
    test_back_to_back();
    test_reset_mid_squash();
    test_kill_zero();
    test_cnt_wrap();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
